// File: rtl/fp_mult_sched.sv
// ============================================================================
// Module      : fp_mult_sched
// Description : Round-robin scheduler sharing one single-precision fp_mult
//               between N_REQ requesters through a 2-stage pipeline.
//               Optional statistics counters: define FP_MULT_SCHED_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

// Single-precision multiplier. Denormal inputs are treated as zero and tiny
// results flush to zero. NaN inputs behave as infinity.
// status: [0] zero [1] infinity [2] invalid [3] tiny [4] huge [5] inexact.
// RND: 0 = IEEE round-to-nearest-even, 1 = round toward zero.
module fp_mult #(
  parameter logic [2:0] RND = 3'd0
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z,
  output logic [7:0]  status
);
  logic              sign, za, zb, ia, ib, g, st, inc, inexact;
  logic [47:0]       p;
  logic signed [9:0] e;
  logic [22:0]       m;
  logic [23:0]       mr;

  always_comb begin
    sign    = a[31] ^ b[31];
    za      = (a[30:23] == 8'h00);
    zb      = (b[30:23] == 8'h00);
    ia      = (a[30:23] == 8'hff);
    ib      = (b[30:23] == 8'hff);
    p       = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e       = 10'(a[30:23]) + 10'(b[30:23]) - 10'sd127;
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    inc     = (RND == 3'd0) ? (g & (st | m[0])) : 1'b0;
    mr      = {1'b0, m} + 24'(inc);
    // A carry out of the mantissa leaves the low bits all zero.
    if (mr[23]) e = e + 10'sd1;
    inexact = g | st;
    z       = 32'h0;
    status  = 8'h00;
    if ((ia && zb) || (ib && za)) begin
      z      = 32'h7fc0_0000;
      status = 8'h04;
    end else if (ia || ib) begin
      z      = {sign, 8'hff, 23'h0};
      status = 8'h02;
    end else if (za || zb) begin
      z      = {sign, 31'h0};
      status = 8'h01;
    end else if (e > 10'sd254) begin
      if (RND == 3'd0) begin
        z      = {sign, 8'hff, 23'h0};
        status = 8'h32;
      end else begin
        z      = {sign, 8'hfe, 23'h7fffff};
        status = 8'h30;
      end
    end else if (e < 10'sd1) begin
      z      = {sign, 31'h0};
      status = 8'h29;
    end else begin
      z      = {sign, e[7:0], mr[22:0]};
      status = {2'b00, inexact, 5'b00000};
    end
  end
endmodule

module fp_mult_sched #(
  parameter int         N_REQ = 4,
  parameter logic [2:0] ROUND = 3'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*32-1:0]      req_a,
  input  logic [N_REQ*32-1:0]      req_b,
  input  logic                     drain,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [31:0]              rsp_z,
  output logic [7:0]               rsp_status,
  output logic                     busy
`ifdef FP_MULT_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_ops,
  output logic [31:0]              stat_stall
`endif
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, gnt_id, s1_id;
  logic            gnt_found, grant_en, accept, stall, s1_vld;
  logic [31:0]     s1_a, s1_b, mul_z;
  logic [7:0]      mul_st;
  int              idx;

  assign stall    = rsp_valid & ~rsp_ready;
  assign grant_en = (state == RUN) & ~drain & ~stall;
  assign accept   = grant_en & gnt_found;
  assign busy     = s1_vld | rsp_valid;

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
    req_ready = accept ? (N_REQ'(1) << gnt_id) : '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!drain) state_nxt = RUN;
      RUN:     if (drain) state_nxt = DRAIN;
      DRAIN: begin
        if (!drain)                    state_nxt = RUN;
        else if (!s1_vld && !rsp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  fp_mult #(.RND(ROUND)) u_mult (
    .a      (s1_a),
    .b      (s1_b),
    .z      (mul_z),
    .status (mul_st)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      s1_vld     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_id      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_z      <= '0;
      rsp_status <= '0;
    end else begin
      state <= state_nxt;
      if (!stall) begin
        s1_vld    <= accept;
        rsp_valid <= s1_vld;
        if (accept) begin
          s1_a   <= req_a[32*gnt_id +: 32];
          s1_b   <= req_b[32*gnt_id +: 32];
          s1_id  <= gnt_id;
          rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
        if (s1_vld) begin
          rsp_id     <= s1_id;
          rsp_z      <= mul_z;
          rsp_status <= mul_st;
        end
      end
    end
  end

`ifdef FP_MULT_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (rsp_valid && rsp_ready && stat_ops != 32'hffff_ffff) stat_ops <= stat_ops + 32'd1;
      if (stall && stat_stall != 32'hffff_ffff) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

`default_nettype wire

// File: tb/tb_fp_mult_sched.sv
// ============================================================================
// Module      : tb_fp_mult_sched
// Description : Randomized self-checking bench for fp_mult_sched against a
//               transaction-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_mult_sched;
  localparam int N = 4;

  logic           clk, rst, drain, rsp_valid, rsp_ready, busy;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [1:0]     rsp_id;
  logic [31:0]    rsp_z;
  logic [7:0]     rsp_status;
`ifdef FP_MULT_SCHED_STATS_EN
  logic [31:0]    stat_ops, stat_stall;
`endif

  fp_mult_sched #(.N_REQ(N), .ROUND(3'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .drain      (drain),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_z      (rsp_z),
    .rsp_status (rsp_status),
    .busy       (busy)
`ifdef FP_MULT_SCHED_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_stall (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] z;
    logic [7:0]  st;
    int          age;
  } txn_t;

  txn_t        q[$];
  int          n_chk = 0, n_fail = 0;
  int          m_ptr = 0, m_phase = 0, last_grant = -1, last_id = -1;
  longint      m_ops = 0, m_stall = 0;
  logic [31:0] last_z = '0;
  logic [7:0]  last_st = '0;
  logic [N-1:0] nx_valid = '0;
  logic [31:0] nx_a[N], nx_b[N];
  logic        nx_drain = 1'b0, nx_rsp_ready = 1'b1;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference product: exact integer product, then normalise and round.
  function automatic logic [39:0] fp_ref(logic [31:0] a, logic [31:0] b);
    logic   s  = a[31] ^ b[31];
    int     ea = int'(a[30:23]);
    int     eb = int'(b[30:23]);
    longint p, rem, half, m;
    int     e, msb, sh;
    logic   inex;
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return {8'h04, 32'h7fc0_0000};
    if (ea == 255 || eb == 255) return {8'h02, s, 8'hff, 23'h0};
    if (ea == 0 || eb == 0) return {8'h01, s, 31'h0};
    p    = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    msb  = (p >= (64'sd1 <<< 47)) ? 47 : 46;
    sh   = msb - 23;
    e    = ea + eb - 127 + (msb - 46);
    rem  = p & ((64'sd1 <<< sh) - 1);
    m    = p >>> sh;
    half = 64'sd1 <<< (sh - 1);
    if (rem > half || (rem == half && m[0])) m = m + 1;
    if (m == (64'sd1 <<< 24)) begin
      m = m >>> 1;
      e = e + 1;
    end
    inex = (rem != 0);
    if (e >= 255) return {8'h32, s, 8'hff, 23'h0};
    if (e <= 0) return {8'h29, s, 31'h0};
    return {2'b00, inex, 5'b00000, s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic sg = 1'($urandom);
    case ($urandom_range(0, 24))
      0:       return {sg, 31'h0};
      1:       return {sg, 8'hff, 23'h0};
      2:       return {sg, 8'h00, 23'($urandom_range(1, 8388607))};
      3:       return 32'h7f7f_ffff;
      4:       return 32'h7fc0_0001;
      5:       return {sg, 8'($urandom_range(1, 63)), 23'($urandom)};
      6:       return {sg, 8'($urandom_range(191, 254)), 23'($urandom)};
      default: return {sg, 8'($urandom_range(64, 190)), 23'($urandom)};
    endcase
  endfunction

  // One clock cycle: apply inputs, compare outputs, advance the model.
  task automatic step();
    logic         vis, stall_m, busy_m;
    logic [N-1:0] exp_ready;
    logic [39:0]  r;
    int           g;
    @(negedge clk);
    req_valid = nx_valid;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = nx_a[i];
      req_b[32*i +: 32] = nx_b[i];
    end
    drain     = nx_drain;
    rsp_ready = nx_rsp_ready;
    #2;
    busy_m  = (q.size() != 0);
    vis     = busy_m && q[0].age >= 2;
    stall_m = vis && !rsp_ready;
    g = -1;
    if (m_phase == 1 && !drain && !stall_m)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_ready = (g >= 0) ? N'(1) << g : '0;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(vis));
    check("busy", 64'(busy), 64'(busy_m));
    if (vis && rsp_valid) begin
      check("rsp_id", 64'(rsp_id), 64'(q[0].id));
      check("rsp_z", 64'(rsp_z), 64'(q[0].z));
      check("rsp_status", 64'(rsp_status), 64'(q[0].st));
    end
    last_grant = g;
    if (vis && rsp_ready) begin
      last_z  = rsp_z;
      last_st = rsp_status;
      last_id = int'(rsp_id);
      void'(q.pop_front());
      m_ops++;
    end
    if (!stall_m) begin
      for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
      if (g >= 0) begin
        r = fp_ref(nx_a[g], nx_b[g]);
        q.push_back('{g, r[31:0], r[39:32], 1});
        m_ptr = (g + 1) % N;
      end
    end else begin
      m_stall++;
    end
    case (m_phase)
      0:       if (!drain) m_phase = 1;
      1:       if (drain) m_phase = 2;
      default: if (!drain) m_phase = 1; else if (!busy_m) m_phase = 0;
    endcase
  endtask

  task automatic model_clear();
    q.delete();
    m_ptr   = 0;
    m_phase = 0;
    m_ops   = 0;
    m_stall = 0;
  endtask

  // Asynchronous reset asserted between edges, released after a rising edge.
  task automatic mid_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_z", 64'(rsp_z), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_rsp_status", 64'(rsp_status), 64'(0));
    model_clear();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_grant(int who);
    for (int t = 0; t < 6; t++) begin
      step();
      if (last_grant >= 0) break;
    end
    check("grant_seen", 64'(last_grant), 64'(who));
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; drain = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      nx_a[i] = 32'h0;
      nx_b[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #2;
    check("init_rsp_valid", 64'(rsp_valid), 64'(0));
    check("init_busy", 64'(busy), 64'(0));
    check("init_rsp_z", 64'(rsp_z), 64'(0));
    rst = 1'b1;

    // Single multiply from requester 0: 1.5 * 2.0
    nx_valid = 4'b0001; nx_a[0] = 32'h3fc0_0000; nx_b[0] = 32'h4000_0000;
    wait_grant(0);
    nx_valid = '0;
    repeat (4) step();
    check("t1_z", 64'(last_z), 64'h4040_0000);
    check("t1_id", 64'(last_id), 64'(0));
    check("t1_status", 64'(last_st), 64'(0));

    // All requesters streaming 1.0 * 2.0
    nx_valid = '1;
    for (int i = 0; i < N; i++) begin
      nx_a[i] = 32'h3f80_0000;
      nx_b[i] = 32'h4000_0000;
    end
    repeat (10) step();
    // Consumer stalls for 5 cycles mid-stream
    nx_rsp_ready = 1'b0;
    repeat (5) step();
    nx_rsp_ready = 1'b1;
    repeat (6) step();
    check("t2_z", 64'(last_z), 64'h4000_0000);

    // Drain with ops in flight, then resume
    nx_drain = 1'b1;
    repeat (12) step();
    check("t4_busy", 64'(busy), 64'(0));
    nx_drain = 1'b0;
    step();
    check("t4_idle_cycle", 64'(last_grant < 0), 64'(1));
    step();
    check("t4_resume", 64'(last_grant >= 0), 64'(1));
    nx_valid = '0;
    repeat (4) step();

    // Overflow: largest finite squared
    nx_valid = 4'b0010; nx_a[1] = 32'h7f7f_ffff; nx_b[1] = 32'h7f7f_ffff;
    wait_grant(1);
    nx_valid = '0;
    repeat (4) step();
    check("t6_z", 64'(last_z), 64'h7f80_0000);
    check("t6_status", 64'(last_st), 64'h32);

    // Reset mid-stream, then lowest valid index from 0 wins
    nx_valid = '1;
    repeat (6) step();
    mid_reset();
    nx_valid = 4'b1010;
    wait_grant(1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) nx_a[i] = rand_op();
        if ($urandom_range(0, 2) == 0) nx_b[i] = rand_op();
      end
      nx_valid     = N'($urandom);
      nx_rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) nx_drain = ~nx_drain;
      if ($urandom_range(0, 199) == 0) mid_reset();
      step();
    end

    nx_valid = '0; nx_drain = 1'b0; nx_rsp_ready = 1'b1;
    repeat (5) step();
`ifdef FP_MULT_SCHED_STATS_EN
    @(negedge clk);
    #2;
    check("stat_ops", 64'(stat_ops), 64'(m_ops));
    check("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
